// File: rtl/mandel_pkg.sv
// Shared constants and types for the mandelbrot pixel pipeline.
// The dispatcher and the result combinator both import this package.
package mandel_pkg;
  localparam int NUM_ENGINES   = 6;
  localparam int DATA_WIDTH    = 32;
  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;

  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN} dispatch_state_t;

  // Counter width for a range of n values. Never returns 0, so a
  // one-engine or one-pixel build still has a legal vector width.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pixel_dispatcher_if.sv
// Frame-control and engine-array signals for the pixel dispatcher.
// The master modport is the dispatcher side; slave is the environment side.
interface pixel_dispatcher_if #(
  parameter int NUM_ENGINES = mandel_pkg::NUM_ENGINES,
  parameter int DATA_WIDTH  = mandel_pkg::DATA_WIDTH
);
  logic                   frame_start;
  logic [NUM_ENGINES-1:0] engine_idle;
  logic [NUM_ENGINES-1:0] queue_full;
  logic [NUM_ENGINES-1:0] start_o;
  logic [DATA_WIDTH-1:0]  x_o;
  logic [DATA_WIDTH-1:0]  y_o;
  logic                   busy;
  logic                   frame_done;

  modport master (
    input  frame_start, engine_idle, queue_full,
    output start_o, x_o, y_o, busy, frame_done
  );

  modport slave (
    output frame_start, engine_idle, queue_full,
    input  start_o, x_o, y_o, busy, frame_done
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first eligible requester at or
// after i_ptr, wrapping. Returns a one-hot grant, a valid flag and the index.
module rr_arbiter #(
  parameter  int NUM_ENGINES = mandel_pkg::NUM_ENGINES,
  localparam int IW          = mandel_pkg::cnt_w(NUM_ENGINES)
) (
  input  logic [NUM_ENGINES-1:0] i_eligible,
  input  logic [IW-1:0]          i_ptr,
  output logic [NUM_ENGINES-1:0] o_grant,
  output logic                   o_valid,
  output logic [IW-1:0]          o_idx
);
  int w_e;

  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    o_idx   = '0;
    w_e     = 0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      w_e = int'(i_ptr) + k;
      if (w_e >= NUM_ENGINES) w_e = w_e - NUM_ENGINES;
      if (!o_valid && i_eligible[w_e]) begin
        o_valid      = 1'b1;
        o_grant[w_e] = 1'b1;
        o_idx        = IW'(w_e);
      end
    end
  end
endmodule

// File: rtl/pixel_dispatcher.sv
// Raster-order pixel scheduler: hands one pixel per cycle to an idle engine
// with room in its output queue, sharing engines round-robin.
module pixel_dispatcher #(
  parameter int NUM_ENGINES   = mandel_pkg::NUM_ENGINES,
  parameter int DATA_WIDTH    = mandel_pkg::DATA_WIDTH,
  parameter int SCREEN_WIDTH  = mandel_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = mandel_pkg::SCREEN_HEIGHT
) (
  input logic               clk,
  input logic               reset,
  pixel_dispatcher_if.master bus
);
  import mandel_pkg::*;

  localparam int XW = cnt_w(SCREEN_WIDTH);
  localparam int YW = cnt_w(SCREEN_HEIGHT);
  localparam int IW = cnt_w(NUM_ENGINES);
  localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);
  localparam logic [IW-1:0] P_LAST = IW'(NUM_ENGINES - 1);

  dispatch_state_t r_state, w_next;

  logic [XW-1:0]          r_x;
  logic [YW-1:0]          r_y;
  logic [IW-1:0]          r_ptr;
  logic [NUM_ENGINES-1:0] r_start, r_hold2;
  logic [DATA_WIDTH-1:0]  r_x_o, r_y_o;
  logic                   r_busy, r_done;

  logic [NUM_ENGINES-1:0] w_holdoff, w_eligible, w_gnt_oh;
  logic                   w_gnt_vld;
  logic [IW-1:0]          w_gnt_idx;
  logic                   w_grant, w_done, w_start_frame, w_last;

  // An engine stays masked for the cycle its start pulse is on the wire and
  // the following cycle, while its idle flag is still catching up.
  assign w_holdoff  = r_start | r_hold2;
  assign w_eligible = bus.engine_idle & ~bus.queue_full & ~w_holdoff;
  assign w_last     = (r_x == X_LAST) && (r_y == Y_LAST);

  rr_arbiter #(.NUM_ENGINES(NUM_ENGINES)) u_arb (
    .i_eligible (w_eligible),
    .i_ptr      (r_ptr),
    .o_grant    (w_gnt_oh),
    .o_valid    (w_gnt_vld),
    .o_idx      (w_gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_grant       = 1'b0;
    w_done        = 1'b0;
    w_start_frame = 1'b0;
    unique case (r_state)
      // A start arriving while the done pulse is still out is dropped.
      IDLE: if (bus.frame_start && !r_done) begin
        w_next        = DISPATCH;
        w_start_frame = 1'b1;
      end
      DISPATCH: if (w_gnt_vld) begin
        w_grant = 1'b1;
        if (w_last) w_next = DRAIN;
      end
      DRAIN: if ((&bus.engine_idle) && (w_holdoff == '0)) begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_ptr   <= '0;
      r_start <= '0;
      r_hold2 <= '0;
      r_x_o   <= '0;
      r_y_o   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_start <= w_grant ? w_gnt_oh : '0;
      r_hold2 <= r_start;
      r_busy  <= (w_next != IDLE);
      r_done  <= w_done;
      if (w_start_frame) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_grant) begin
        r_x_o <= DATA_WIDTH'(r_x);
        r_y_o <= DATA_WIDTH'(r_y);
        r_ptr <= (w_gnt_idx == P_LAST) ? '0 : w_gnt_idx + IW'(1);
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
    end
  end

  assign bus.start_o    = r_start;
  assign bus.x_o        = r_x_o;
  assign bus.y_o        = r_y_o;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done;
endmodule

// File: tb/tb_pixel_dispatcher.sv
// Randomized scoreboard bench for pixel_dispatcher: a pixel-index reference
// model predicts every start pulse and status bit; a monitor compares.
module tb_pixel_dispatcher;
  localparam int NE = 3, DW = 32, SW = 4, SH = 2, NPIX = SW * SH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pixel_dispatcher_if #(.NUM_ENGINES(NE), .DATA_WIDTH(DW)) bus ();

  pixel_dispatcher #(
    .NUM_ENGINES(NE), .DATA_WIDTH(DW), .SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { int cyc; int eng; int x; int y; } ev_t;
  ev_t exp_q[$];

  int total = 0, bad = 0;
  int cyc = 0;

  // reference model state
  int m_phase, m_n, m_ptr;
  int m_last[NE];
  bit m_busy = 1'b0, m_done = 1'b0;

  // engine model / observation
  int rem[NE];
  logic [NE-1:0] idle_mask = '1;
  int busy_len = 5;
  int pulses[NE];
  int pulses_all = 0;
  int eng_log[$], x_log[$], y_log[$];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: frame = sequence of pixel indices 0..NPIX-1, an engine is
  // usable if idle, its queue has room and it was not granted in the last 2 cycles.
  initial begin
    m_phase = 0; m_n = 0; m_ptr = 0;
    for (int i = 0; i < NE; i++) m_last[i] = -100;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_phase = 0; m_n = 0; m_ptr = 0;
        for (int i = 0; i < NE; i++) m_last[i] = -100;
        m_busy = 1'b0; m_done = 1'b0;
      end else begin
        bit nd;
        bit found;
        bit quiet;
        nd = 1'b0;
        found = 1'b0;
        if (m_phase == 0) begin
          if (bus.frame_start && !m_done) begin m_phase = 1; m_n = 0; end
        end else if (m_phase == 1) begin
          for (int k = 0; k < NE; k++) begin
            int e;
            e = (m_ptr + k) % NE;
            if (!found && bus.engine_idle[e] && !bus.queue_full[e] && (cyc - m_last[e] >= 3)) begin
              found = 1'b1;
              exp_q.push_back('{cyc + 1, e, m_n % SW, m_n / SW});
              m_last[e] = cyc;
              m_ptr = (e + 1) % NE;
              m_n++;
              if (m_n == NPIX) m_phase = 2;
            end
          end
        end else begin
          quiet = 1'b1;
          for (int i = 0; i < NE; i++) if (cyc - m_last[i] < 3) quiet = 1'b0;
          if ((&bus.engine_idle) && quiet) begin nd = 1'b1; m_phase = 0; end
        end
        m_done = nd;
        m_busy = (m_phase != 0);
      end
      cyc = cyc + 1;
    end
  end

  // Engines: busy for busy_len cycles (random 1..6 when 0) after a start pulse.
  initial begin
    for (int i = 0; i < NE; i++) rem[i] = 0;
    bus.engine_idle = '1;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NE; i++) begin
        if (reset) rem[i] = 0;
        else if (bus.start_o[i]) rem[i] = (busy_len == 0) ? int'($urandom_range(1, 6)) : busy_len;
        else if (rem[i] > 0) rem[i]--;
        bus.engine_idle[i] = (rem[i] == 0) && idle_mask[i];
      end
    end
  end

  // Monitor
  initial begin
    for (int i = 0; i < NE; i++) pulses[i] = 0;
    forever begin
      @(negedge clk);
      chk("busy", bus.busy, m_busy);
      chk("frame_done", bus.frame_done, m_done);
      if (bus.start_o != '0) begin
        if (exp_q.size() == 0) chk("spurious_start", bus.start_o, 0);
        else begin
          ev_t ev;
          ev = exp_q.pop_front();
          chk("start_cycle", cyc, ev.cyc);
          chk("start_o", bus.start_o, 1 << ev.eng);
          chk("x_o", bus.x_o, ev.x);
          chk("y_o", bus.y_o, ev.y);
        end
        for (int i = 0; i < NE; i++) if (bus.start_o[i]) begin
          pulses[i]++;
          eng_log.push_back(i);
        end
        x_log.push_back(int'(bus.x_o));
        y_log.push_back(int'(bus.y_o));
        pulses_all++;
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_start", 0, 1 << exp_q[0].eng);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      bus.frame_start = 1'($urandom);
      bus.queue_full  = NE'($urandom);
      idle_mask       = NE'($urandom);
    end
    chk("reset_start_o", bus.start_o, 0);
    chk("reset_x_o", bus.x_o, 0);
    chk("reset_y_o", bus.y_o, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.frame_done, 0);
    reset = 1'b0;
    bus.frame_start = 1'b0;
    bus.queue_full  = '0;
    idle_mask       = '1;
  endtask

  task automatic pulse_start;
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  task automatic wait_pulses(input int target, input int bound);
    int n;
    n = 0;
    while (pulses_all < target && n < bound) begin @(negedge clk); n++; end
    if (pulses_all < target) chk("timeout_pulses", pulses_all, target);
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!bus.frame_done && n < bound) begin @(negedge clk); n++; end
    if (!bus.frame_done) chk("timeout_frame_done", 0, 1);
  endtask

  int base, snap, b1;

  initial begin
    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.queue_full  = '0;
    do_reset(3);
    tick(6);
    chk("idle_no_busy", bus.busy, 0);

    // full rate
    busy_len = 5;
    base = pulses_all;
    pulse_start;
    wait_done(300);
    chk("fullrate_count", pulses_all - base, NPIX);
    chk("fullrate_p0_eng", eng_log[base], 0);
    chk("fullrate_p2_eng", eng_log[base + 2], 2);
    chk("fullrate_p2_x", x_log[base + 2], 2);
    chk("fullrate_p4_y", y_log[base + 4], 1);

    // masking: engine 1 queue always full
    do_reset(2);
    busy_len = 0;
    bus.queue_full = 3'b010;
    base = pulses_all; b1 = pulses[1];
    pulse_start;
    wait_done(400);
    chk("mask_eng1", pulses[1] - b1, 0);
    chk("mask_count", pulses_all - base, NPIX);
    bus.queue_full = '0;

    // starvation mid-frame
    do_reset(2);
    busy_len = 2;
    base = pulses_all;
    pulse_start;
    wait_pulses(base + 3, 100);
    idle_mask = '0;
    tick(2);
    snap = pulses_all;
    tick(8);
    chk("starve_frozen", pulses_all, snap);
    idle_mask = 3'b100;
    wait_pulses(snap + 1, 100);
    chk("resume_eng", eng_log[snap], 2);
    chk("resume_x", x_log[snap], (snap - base) % SW);
    chk("resume_y", y_log[snap], (snap - base) / SW);
    idle_mask = '1;
    wait_done(300);
    chk("starve_count", pulses_all - base, NPIX);

    // drain: engine 1 held busy after the last grant
    do_reset(2);
    busy_len = 1;
    base = pulses_all;
    pulse_start;
    wait_pulses(base + NPIX, 200);
    idle_mask = 3'b101;
    tick(7);
    chk("drain_busy", bus.busy, 1);
    chk("drain_no_done", bus.frame_done, 0);
    idle_mask = '1;
    wait_done(50);
    chk("done_busy_low", bus.busy, 0);
    pulse_start;   // coincides with frame_done: must be ignored
    tick(4);
    chk("start_on_done_ignored", bus.busy, 0);

    // reset mid-frame, then a stray frame_start during dispatch
    base = pulses_all;
    pulse_start;
    wait_pulses(base + 3, 100);
    do_reset(2);
    base = pulses_all;
    pulse_start;
    wait_pulses(base + 1, 20);
    chk("rst_restart_eng", eng_log[base], 0);
    chk("rst_restart_x", x_log[base], 0);
    chk("rst_restart_y", y_log[base], 0);
    pulse_start;
    wait_done(300);
    chk("rst_count", pulses_all - base, NPIX);

    // random frames back to back, pointer carried between frames
    busy_len = 0;
    for (int f = 0; f < 4; f++) begin
      int n;
      tick(2);
      base = pulses_all;
      pulse_start;
      n = 0;
      while (!bus.frame_done && n < 2000) begin
        @(negedge clk);
        bus.queue_full = NE'($urandom);
        for (int i = 0; i < NE; i++) idle_mask[i] = ($urandom_range(0, 3) != 0);
        n++;
      end
      if (!bus.frame_done) chk("timeout_random_frame", 0, 1);
      bus.queue_full = '0;
      idle_mask = '1;
      chk("random_count", pulses_all - base, NPIX);
    end

    tick(4);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
